aes_inv_key_gen: RTL and testbench
==================================

# aes_inv_key_gen

Inverse AES-128 key schedule for the decryption datapath. Loaded with the final round key (round 10), it walks the schedule backwards and delivers round keys 10 down to 0, one per accepted transfer on a valid/ready output. It shares the external combinational S-box port style of the forward key generator and feeds the inverse-round pipeline.

## Interface
- NR, 10, number of rounds. Only 10 is supported (AES-128).
- RCON_LAST, 8'h36, round constant used for the 10→9 step.

- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start_i  in  1  load request. Sampled only in IDLE.
- key_i  in  128  round-10 key. Word 0 = [127:96], word 3 = [31:0]. Byte 0 of a word = its MSB byte.
- sub_o  out  32  word sent to the external S-box (combinational from state).
- sub_i  in  32  SubWord(sub_o), returned combinationally in the same cycle.
- rk_o  out  128  current round key.
- rk_round_o  out  4  round index of rk_o (10..0).
- rk_valid_o  out  1  rk_o is valid.
- rk_ready_i  in  1  consumer accepts rk_o.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- State: key_r (128), rcon_r (8), rnd_r (4). FSM states are IDLE and OUT.
- **IDLE**
  - On start_i: key_r←key_i, rcon_r←RCON_LAST, rnd_r←10, go to OUT.
  - Otherwise hold.
- **OUT**
  - rk_valid_o=1, rk_o=key_r, rk_round_o=rnd_r.
  - On rk_valid_o&&rk_ready_i with rnd_r≠0: key_r←prev, rnd_r←rnd_r−1, rcon_r←inv_xtime(rcon_r), stay in OUT.
  - On accept with rnd_r==0: go to IDLE and pulse done_o for the next cycle.
  - Without ready: all state holds; rk_o and rk_round_o are stable.
- **Previous-key math.** Let k0..k3 be the words of key_r.
  - p3=k3^k2, p2=k2^k1, p1=k1^k0.
  - sub_o = RotWord(p3) = {p3[23:0], p3[31:24]}.
  - p0 = k0 ^ sub_i ^ {rcon_r, 24'h0}.
  - prev = {p0, p1, p2, p3}.
- **inv_xtime(x)** = x[0] ? (((x^8'h1b)>>1) | 8'h80) : (x>>1).
  - Sequence: 36,1b,80,40,20,10,08,04,02,01.
- Width rules: all XOR arithmetic is 32-bit per word. rnd_r never wraps below 0.
- start_i is ignored outside IDLE, including the final-accept cycle.
- rk_ready_i in IDLE has no effect.
- Reset (async, any time, mid-walk included): IDLE, key_r=0, rcon_r=0, rnd_r=0.
  - Reset values of outputs: rk_valid_o=0, rk_o=0, rk_round_o=0, busy_o=0, done_o=0, sub_o=0.
  - A walk in progress is abandoned and is not resumed.

## Timing
- start_i sampled high at edge t gives rk_valid_o=1 with round 10 from t+1.
- Accept at edge t gives the next round key valid from t+1. There are no bubbles.
- With ready held high, 11 keys take 11 cycles after load.
- Full walk with ready high: start at edge 0, round 10..0 visible in cycles 1..11, done_o=1 and busy_o=0 in cycle 12.
- sub_o/sub_i is a purely combinational loop inside one cycle. The S-box must not be registered.
- done_o is registered and is high for exactly one cycle.

## Configuration
- Macro: AES_INV_KEY_CHECK_EN.
- **Defined:**
  - Adds port exp_key_i (in, 128, expected cipher key) and port key_match_o (out, 1).
  - On the accept of round 0, key_match_o←(key_r==exp_key_i) and holds until the next start_i load. A load clears it to 0.
  - Reset value is 0.
- **Undefined:** the ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- FIPS-197 walk, ready always high.
  - Stimulus: key_i=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Cycle 1: round 10 equals key_i.
  - Cycle 2: round 9 = ac7766f319fadc2128d12941575c006e.
  - Cycle 11: round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Then done_o is a 1-cycle pulse.
- Backpressure: hold rk_ready_i low for 5 cycles at round 7 -> rk_o and rk_round_o stay stable, rcon order is unchanged, and the final key is still 2b7e1516….
- start_i pulsed at round 4 and in the final-accept cycle -> ignored. The walk completes normally.
- nrst asserted at round 5 -> all outputs 0 immediately. After release and a new start, round 10 appears one cycle after start.
- Rcon sweep: probe rcon_r across a walk -> 36,1b,80,40,20,10,08,04,02,01.
- With AES_INV_KEY_CHECK_EN:
  - exp_key_i=2b7e1516… -> key_match_o=1 after round 0.
  - Flip bit 0 of exp_key_i -> key_match_o=0.
  - Next start_i -> key_match_o clears to 0.

Source files
------------

// File: rtl/aes_inv_key_gen_if.sv
// Round-key delivery bus and external S-box port of the inverse AES-128 key schedule.
// master = key generator, slave = round-key consumer that also hosts the S-box.
interface aes_inv_key_gen_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [31:0]  sub_o;
  logic [31:0]  sub_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         busy_o;
  logic         done_o;

  modport master (
    input  start_i, key_i, sub_i, rk_ready_i,
    output sub_o, rk_o, rk_round_o, rk_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, key_i, sub_i, rk_ready_i,
    input  sub_o, rk_o, rk_round_o, rk_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: round keys 10..0, one per rk accept, valid the cycle after start, stalls on !rk_ready_i.
// Optional cipher-key compare (ports exp_key_i/key_match_o) under `AES_INV_KEY_CHECK_EN.
module aes_inv_key_gen #(
  parameter int          NR        = 10,
  parameter logic [7:0]  RCON_LAST = 8'h36
) (
  input  logic               clk,
  input  logic               nrst,
  aes_inv_key_gen_if.master  kg
`ifdef AES_INV_KEY_CHECK_EN
  ,
  input  logic [127:0]       exp_key_i,
  output logic               key_match_o
`endif
);

  localparam logic [3:0] RND_LAST = 4'(NR);

  typedef enum logic {IDLE, OUT} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
`ifdef AES_INV_KEY_CHECK_EN
  logic         match_q, match_d;
`endif

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [127:0] prev;
  logic         accept;

  // Inverse of xtime over GF(2^8): undoes the rcon doubling of the forward schedule.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  always_comb begin
    k0   = key_q[127:96];
    k1   = key_q[95:64];
    k2   = key_q[63:32];
    k3   = key_q[31:0];
    p3   = k3 ^ k2;
    p2   = k2 ^ k1;
    p1   = k1 ^ k0;
    p0   = k0 ^ kg.sub_i ^ {rcon_q, 24'h0};
    prev = {p0, p1, p2, p3};
  end

  // S-box lookup is outside the block and closes the loop within the same cycle.
  assign kg.sub_o      = {p3[23:0], p3[31:24]};
  assign kg.rk_o       = key_q;
  assign kg.rk_round_o = rnd_q;
  assign kg.rk_valid_o = (state_q == OUT);
  assign kg.busy_o     = (state_q != IDLE);
  assign kg.done_o     = done_q;
  assign accept        = kg.rk_valid_o && kg.rk_ready_i;
`ifdef AES_INV_KEY_CHECK_EN
  assign key_match_o   = match_q;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
`ifdef AES_INV_KEY_CHECK_EN
    match_d = match_q;
`endif
    case (state_q)
      IDLE: begin
        if (kg.start_i) begin
          state_d = OUT;
          key_d   = kg.key_i;
          rcon_d  = RCON_LAST;
          rnd_d   = RND_LAST;
`ifdef AES_INV_KEY_CHECK_EN
          match_d = 1'b0;
`endif
        end
      end
      OUT: begin
        if (accept) begin
          if (rnd_q != 4'd0) begin
            key_d  = prev;
            rnd_d  = rnd_q - 4'd1;
            rcon_d = inv_xtime(rcon_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef AES_INV_KEY_CHECK_EN
            match_d = (key_q == exp_key_i);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
`ifdef AES_INV_KEY_CHECK_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
`ifdef AES_INV_KEY_CHECK_EN
      match_q <= match_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Directed bench for aes_inv_key_gen using the FIPS-197 AES-128 example schedule and a computed S-box.
module tb_aes_inv_key_gen;

  logic clk;
  logic nrst;
  aes_inv_key_gen_if bus ();
`ifdef AES_INV_KEY_CHECK_EN
  logic [127:0] exp_key;
  logic         key_match;
`endif

  aes_inv_key_gen dut (
    .clk        (clk),
    .nrst       (nrst),
    .kg         (bus)
`ifdef AES_INV_KEY_CHECK_EN
    ,
    .exp_key_i  (exp_key),
    .key_match_o(key_match)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_rk   [0:10];
  logic [7:0]   exp_rcon [1:10];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box = affine(x^254) in GF(2^8).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01; s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb bus.sub_i = {sbox(bus.sub_o[31:24]), sbox(bus.sub_o[23:16]),
                           sbox(bus.sub_o[15:8]),  sbox(bus.sub_o[7:0])};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    bus.key_i   = k;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic run_walk();
    bus.rk_ready_i = 1'b1;
    load(exp_rk[10]);
    repeat (11) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    if ({bus.rk_valid_o, bus.busy_o, bus.done_o} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {bus.rk_valid_o, bus.busy_o, bus.done_o}); else n_pass++;
    n_total++;
    if ({bus.rk_round_o, bus.rk_o, bus.sub_o} !== '0) $display("FAIL reset_data got round=%0d rk=%h sub=%h exp all 0", bus.rk_round_o, bus.rk_o, bus.sub_o); else n_pass++;
    n_total++;
    @(posedge clk); #1;
    nrst = 1'b1;
    bus.rk_ready_i = 1'b1;
    repeat (3) step();
    if ({bus.rk_valid_o, bus.busy_o, bus.done_o} !== 3'b000) $display("FAIL idle_ready got=%b exp=000", {bus.rk_valid_o, bus.busy_o, bus.done_o}); else n_pass++;
    n_total++;
  endtask

  task automatic test_fips_walk();
    bus.rk_ready_i = 1'b1;
    load(exp_rk[10]);
    for (int r = 10; r >= 0; r--) begin
      if ({bus.rk_valid_o, bus.busy_o, bus.done_o, bus.rk_round_o, bus.rk_o} !== {3'b110, 4'(r), exp_rk[r]})
        $display("FAIL walk_r%0d got vld=%b busy=%b done=%b round=%0d key=%h exp key=%h", r, bus.rk_valid_o, bus.busy_o, bus.done_o, bus.rk_round_o, bus.rk_o, exp_rk[r]);
      else n_pass++;
      n_total++;
      if (r > 0) begin
        if (dut.rcon_q !== exp_rcon[r]) $display("FAIL rcon_r%0d got=%h exp=%h", r, dut.rcon_q, exp_rcon[r]); else n_pass++;
        n_total++;
      end
      step();
    end
    if ({bus.rk_valid_o, bus.busy_o, bus.done_o} !== 3'b001) $display("FAIL walk_done got vld/busy/done=%b exp=001", {bus.rk_valid_o, bus.busy_o, bus.done_o}); else n_pass++;
    n_total++;
    step();
    if (bus.done_o !== 1'b0) $display("FAIL done_pulse got=%b exp=0", bus.done_o); else n_pass++;
    n_total++;
  endtask

  task automatic test_backpressure();
    bus.rk_ready_i = 1'b1;
    load(exp_rk[10]);
    for (int r = 10; r >= 0; r--) begin
      if (r == 7) begin
        bus.rk_ready_i = 1'b0;
        repeat (5) begin
          step();
          if ({bus.rk_valid_o, bus.rk_round_o, bus.rk_o, dut.rcon_q} !== {1'b1, 4'd7, exp_rk[7], 8'h40})
            $display("FAIL stall got vld=%b round=%0d key=%h rcon=%h exp round=7 key=%h rcon=40", bus.rk_valid_o, bus.rk_round_o, bus.rk_o, dut.rcon_q, exp_rk[7]);
          else n_pass++;
          n_total++;
        end
        bus.rk_ready_i = 1'b1;
      end
      if (r <= 6) begin
        if ({bus.rk_round_o, bus.rk_o} !== {4'(r), exp_rk[r]}) $display("FAIL bp_r%0d got round=%0d key=%h exp=%h", r, bus.rk_round_o, bus.rk_o, exp_rk[r]); else n_pass++;
        n_total++;
      end
      step();
    end
    if ({bus.busy_o, bus.done_o} !== 2'b01) $display("FAIL bp_done got busy/done=%b exp=01", {bus.busy_o, bus.done_o}); else n_pass++;
    n_total++;
  endtask

  task automatic test_start_ignored();
    bus.rk_ready_i = 1'b1;
    load(exp_rk[10]);
    for (int r = 10; r >= 0; r--) begin
      if (r == 4 || r == 0) begin
        bus.start_i = 1'b1;
        bus.key_i   = '1;
      end else begin
        bus.start_i = 1'b0;
      end
      if ({bus.rk_round_o, bus.rk_o} !== {4'(r), exp_rk[r]}) $display("FAIL ign_r%0d got round=%0d key=%h exp=%h", r, bus.rk_round_o, bus.rk_o, exp_rk[r]); else n_pass++;
      n_total++;
      step();
    end
    bus.start_i = 1'b0;
    if ({bus.rk_valid_o, bus.busy_o, bus.done_o} !== 3'b001) $display("FAIL ign_final got vld/busy/done=%b exp=001", {bus.rk_valid_o, bus.busy_o, bus.done_o}); else n_pass++;
    n_total++;
    step();
    if (bus.busy_o !== 1'b0) $display("FAIL ign_idle got busy=%b exp=0", bus.busy_o); else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_midwalk();
    bus.rk_ready_i = 1'b1;
    load(exp_rk[10]);
    repeat (5) step();
    if ({bus.rk_round_o, bus.rk_o} !== {4'd5, exp_rk[5]}) $display("FAIL mid_r5 got round=%0d key=%h exp=%h", bus.rk_round_o, bus.rk_o, exp_rk[5]); else n_pass++;
    n_total++;
    nrst = 1'b0;
    #1;
    if ({bus.rk_valid_o, bus.busy_o, bus.done_o, bus.rk_round_o, bus.rk_o, bus.sub_o} !== '0)
      $display("FAIL mid_reset got vld=%b busy=%b done=%b round=%0d key=%h sub=%h exp all 0", bus.rk_valid_o, bus.busy_o, bus.done_o, bus.rk_round_o, bus.rk_o, bus.sub_o);
    else n_pass++;
    n_total++;
    @(posedge clk); #1;
    nrst = 1'b1;
    step();
    if (bus.busy_o !== 1'b0) $display("FAIL mid_no_resume got busy=%b exp=0", bus.busy_o); else n_pass++;
    n_total++;
    load(exp_rk[10]);
    if ({bus.rk_valid_o, bus.rk_round_o, bus.rk_o} !== {1'b1, 4'd10, exp_rk[10]}) $display("FAIL mid_restart got vld=%b round=%0d key=%h exp=%h", bus.rk_valid_o, bus.rk_round_o, bus.rk_o, exp_rk[10]); else n_pass++;
    n_total++;
    repeat (10) step();
    if ({bus.rk_round_o, bus.rk_o} !== {4'd0, exp_rk[0]}) $display("FAIL mid_r0 got round=%0d key=%h exp=%h", bus.rk_round_o, bus.rk_o, exp_rk[0]); else n_pass++;
    n_total++;
    step();
  endtask

`ifdef AES_INV_KEY_CHECK_EN
  task automatic test_key_check();
    exp_key = exp_rk[0];
    run_walk();
    if (key_match !== 1'b1) $display("FAIL match_good got=%b exp=1", key_match); else n_pass++;
    n_total++;
    repeat (3) step();
    if (key_match !== 1'b1) $display("FAIL match_hold got=%b exp=1", key_match); else n_pass++;
    n_total++;
    exp_key = exp_rk[0] ^ 128'h1;
    load(exp_rk[10]);
    if (key_match !== 1'b0) $display("FAIL match_clear got=%b exp=0", key_match); else n_pass++;
    n_total++;
    repeat (11) step();
    if (key_match !== 1'b0) $display("FAIL match_bad got=%b exp=0", key_match); else n_pass++;
    n_total++;
  endtask
`endif

  initial begin
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rcon[10] = 8'h36; exp_rcon[9] = 8'h1b; exp_rcon[8] = 8'h80; exp_rcon[7] = 8'h40;
    exp_rcon[6]  = 8'h20; exp_rcon[5] = 8'h10; exp_rcon[4] = 8'h08; exp_rcon[3] = 8'h04;
    exp_rcon[2]  = 8'h02; exp_rcon[1] = 8'h01;

    nrst           = 1'b0;
    bus.start_i    = 1'b0;
    bus.key_i      = '0;
    bus.rk_ready_i = 1'b0;
`ifdef AES_INV_KEY_CHECK_EN
    exp_key        = '0;
`endif

    test_reset();
    test_fips_walk();
    test_backpressure();
    test_start_ignored();
    test_reset_midwalk();
`ifdef AES_INV_KEY_CHECK_EN
    test_key_check();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
